// File: rtl/gpio_pinmux_sync.sv
// Per-pin GPIO / alternate-function pad multiplexer with break-before-make switching.
// Define GPIO_PINMUX_FILTER_EN to compile in the input glitch filter.
module gpio_pinmux_sync #(
    parameter int unsigned PORTWIDTH    = 16,
    parameter int unsigned ALTFUNC      = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FILT_CYCLES  = 4,
    parameter int unsigned GUARD_CYCLES = 2,
    localparam int unsigned SELW        = $clog2(ALTFUNC)
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic [PORTWIDTH-1:0]           PORTOUT,
    input  logic [PORTWIDTH-1:0]           PORTEN,
    input  logic [PORTWIDTH-1:0]           PORTFUNC,
    input  logic [PORTWIDTH*SELW-1:0]      ALT_SEL,
    input  logic [PORTWIDTH*ALTFUNC-1:0]   ALT_FUNC_OUT,
    input  logic [PORTWIDTH*ALTFUNC-1:0]   ALT_FUNC_OE,
    input  logic [PORTWIDTH-1:0]           PAD_IN,
    output logic [PORTWIDTH-1:0]           PAD_OUT,
    output logic [PORTWIDTH-1:0]           PAD_OE,
    output logic [PORTWIDTH-1:0]           PORTIN,
    output logic [PORTWIDTH*ALTFUNC-1:0]   ALT_FUNC_IN,
    output logic [PORTWIDTH-1:0]           SWITCH_BUSY
);

    localparam int unsigned CNTW  = $clog2(GUARD_CYCLES + 1);
    localparam int unsigned FCNTW = $clog2(FILT_CYCLES) + 1;

    typedef enum logic {StActive, StGuard} state_e;

`ifndef GPIO_PINMUX_FILTER_EN
    logic [31:0] filt_cycles_unused;
    assign filt_cycles_unused = 32'(FILT_CYCLES);
`endif

    for (genvar j = 0; j < PORTWIDTH; j++) begin : g_pin
        state_e              state_q;
        logic                act_func_q, pend_func_q;
        logic [SELW-1:0]     act_sel_q, pend_sel_q;
        logic [CNTW-1:0]     cnt_q;
        logic                pad_out_q, pad_oe_q;
        logic                req_func;
        logic [SELW-1:0]     req_sel;
        logic                req_diff, pend_diff;
        logic                mux_out, mux_oe;
        logic [SYNC_STAGES-1:0] sync_q;
        logic                s, filt;

        // Select bits are don't-care in GPIO mode, so normalise them away before comparing.
        assign req_func  = PORTFUNC[j];
        assign req_sel   = PORTFUNC[j] ? ALT_SEL[j*SELW +: SELW] : '0;
        assign req_diff  = {req_func, req_sel} != {act_func_q, act_sel_q};
        assign pend_diff = {req_func, req_sel} != {pend_func_q, pend_sel_q};

        always_comb begin
            mux_out = 1'b0;
            mux_oe  = 1'b0;
            if (!act_func_q) begin
                mux_out = PORTOUT[j];
                mux_oe  = PORTEN[j];
            end else begin
                for (int f = 0; f < ALTFUNC; f++) begin
                    if (act_sel_q == SELW'(f)) begin
                        mux_out = ALT_FUNC_OUT[f*PORTWIDTH + j];
                        mux_oe  = ALT_FUNC_OE[f*PORTWIDTH + j];
                    end
                end
            end
        end

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                state_q     <= StActive;
                act_func_q  <= 1'b0;
                act_sel_q   <= '0;
                pend_func_q <= 1'b0;
                pend_sel_q  <= '0;
                cnt_q       <= '0;
                pad_out_q   <= 1'b0;
                pad_oe_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StActive: begin
                        if (req_diff) begin
                            state_q     <= StGuard;
                            cnt_q       <= CNTW'(GUARD_CYCLES - 1);
                            pend_func_q <= req_func;
                            pend_sel_q  <= req_sel;
                            pad_oe_q    <= 1'b0;
                        end else begin
                            pad_out_q <= mux_out;
                            pad_oe_q  <= mux_oe;
                        end
                    end
                    StGuard: begin
                        // A newer request restarts the blanking interval.
                        if (pend_diff) begin
                            cnt_q       <= CNTW'(GUARD_CYCLES - 1);
                            pend_func_q <= req_func;
                            pend_sel_q  <= req_sel;
                        end else if (cnt_q == '0) begin
                            act_func_q <= pend_func_q;
                            act_sel_q  <= pend_sel_q;
                            state_q    <= StActive;
                        end else begin
                            cnt_q <= cnt_q - CNTW'(1);
                        end
                    end
                    default: state_q <= StActive;
                endcase
            end
        end

        always_ff @(posedge HCLK) begin
            if (HRESET) sync_q <= '0;
            else        sync_q <= {sync_q[SYNC_STAGES-2:0], PAD_IN[j]};
        end
        assign s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_PINMUX_FILTER_EN
        logic [FCNTW-1:0] fcnt_q;
        logic             filt_q;

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                fcnt_q <= '0;
                filt_q <= 1'b0;
            end else if (s == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FCNTW'(FILT_CYCLES - 1)) begin
                fcnt_q <= '0;
                filt_q <= s;
            end else begin
                fcnt_q <= fcnt_q + FCNTW'(1);
            end
        end
        assign filt = filt_q;
`else
        assign filt = s;
`endif

        assign PAD_OUT[j]     = pad_out_q;
        assign PAD_OE[j]      = pad_oe_q;
        assign SWITCH_BUSY[j] = (state_q == StGuard);
        assign PORTIN[j]      = pad_oe_q ? 1'b0 : filt;

        // Peripherals see idle-high unless they currently own the pin.
        for (genvar f = 0; f < ALTFUNC; f++) begin : g_afi
            assign ALT_FUNC_IN[f*PORTWIDTH + j] =
                (state_q == StActive && act_func_q && act_sel_q == SELW'(f)) ? filt : 1'b1;
        end
    end

endmodule
